rgb_pwm_driver: RTL and testbench

//  LED-side endpoint of the active-low rgb colour bus. Accepts a colour code
//  (same active-low 3-bit encoding the sequencers emit) plus a brightness via

---
 rtl/light_pkg.sv | 21 ++
 rtl/rgb_pwm_driver_if.sv | 21 ++
 rtl/pwm_timebase.sv | 36 +++
 rtl/rgb_pwm_driver.sv | 92 +++++++++
 tb/tb_rgb_pwm_driver.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/light_pkg.sv
// Shared definitions for the active-low rgb colour bus: colour codes and the
// handshake state enum used by the sequencers and the LED driver.
package light_pkg;

  localparam logic [2:0] COLOR_RED_N   = 3'b011;
  localparam logic [2:0] COLOR_GREEN_N = 3'b101;
  localparam logic [2:0] COLOR_BLUE_N  = 3'b110;
  localparam logic [2:0] COLOR_OFF_N   = 3'b111;
  localparam logic [2:0] COLOR_ERR_N   = 3'b000;

  typedef enum logic {
    S_IDLE,
    S_PENDING
  } state_t;

  // Active-low colour code to active-high channel enable mask.
  function automatic logic [2:0] color_mask(input logic [2:0] color_n);
    return ~color_n;
  endfunction

endpackage

// File: rtl/rgb_pwm_driver_if.sv
// Setting bus into the LED driver: colour + brightness with valid/ready.
interface rgb_pwm_driver_if #(
  parameter int PWM_BITS = 8
) ();

  logic [2:0]          color_n;
  logic [PWM_BITS-1:0] brightness;
  logic                in_valid;
  logic                in_ready;

  modport master (
    output color_n, brightness, in_valid,
    input  in_ready
  );

  modport slave (
    input  color_n, brightness, in_valid,
    output in_ready
  );

endinterface

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaler feeding a free-running PWM_BITS period counter;
// reports the prescaler tick and the last tick of each period (wrap).
module pwm_timebase #(
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 4
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                tick,
  output logic                wrap
);

  localparam int              PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] prescaler;

  assign tick = (prescaler == PS_MAX);
  assign wrap = tick && (pwm_cnt == '1);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
    end else if (tick) begin
      prescaler <= '0;
      pwm_cnt   <= pwm_cnt + 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

endmodule

// File: rtl/rgb_pwm_driver.sv
// LED-side endpoint of the active-low rgb colour bus: accepts colour and
// brightness, applies them at PWM period boundaries, drives registered pins.
module rgb_pwm_driver
  import light_pkg::*;
#(
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  rgb_pwm_driver_if.slave  cfg,
  output logic [2:0]       rgb,
  output logic             period_start
);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick;
  logic                wrap;
  logic                tick_q;

  state_t              state;
  logic [2:0]          pend_mask;
  logic [PWM_BITS-1:0] pend_duty;
  logic [2:0]          act_mask;
  logic [PWM_BITS-1:0] act_duty;

  logic                accept;
  logic [2:0]          on_now;

  pwm_timebase #(
    .PWM_BITS (PWM_BITS),
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk     (clk),
    .rst     (rst),
    .pwm_cnt (pwm_cnt),
    .tick    (tick),
    .wrap    (wrap)
  );

  assign accept = cfg.in_valid && cfg.in_ready;
  assign on_now = act_mask & {3{pwm_cnt < act_duty}};

  // Compare inputs only move on a tick edge, so the pins re-evaluate the
  // cycle after one; this still gives one clk of latency from pwm_cnt.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: every register here, including the pending/active settings,
      // is explicitly reset so a reset mid-period discards queued work.
      state        <= S_IDLE;
      cfg.in_ready <= 1'b1;
      pend_mask    <= '0;
      pend_duty    <= '0;
      act_mask     <= '0;
      act_duty     <= '0;
      rgb          <= COLOR_OFF_N;
      period_start <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      tick_q       <= tick;
      period_start <= wrap;
      if (tick_q) begin
        rgb <= ~on_now;
      end

      unique case (state)
        S_IDLE: begin
          // A wrap seen here is ignored: a same-cycle accept waits a period.
          if (accept) begin
            pend_mask    <= color_mask(cfg.color_n);
            pend_duty    <= cfg.brightness;
            cfg.in_ready <= 1'b0;
            state        <= S_PENDING;
          end
        end
        S_PENDING: begin
          if (wrap) begin
            act_mask     <= pend_mask;
            act_duty     <= pend_duty;
            cfg.in_ready <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: begin
          cfg.in_ready <= 1'b1;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver at PWM_BITS=4, PRESCALE=2 (32-clk period).
module tb_rgb_pwm_driver;
  import light_pkg::*;

  localparam int PWM_BITS = 4;
  localparam int PRESCALE = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] rgb;
  logic       period_start;

  int checks = 0;
  int errors = 0;

  rgb_pwm_driver_if #(.PWM_BITS(PWM_BITS)) bus ();

  rgb_pwm_driver #(
    .PWM_BITS (PWM_BITS),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg          (bus),
    .rgb          (rgb),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  // One clock; leaves the bench on the falling edge for sampling and driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // After reset release, count clks to the first period_start; pins stay dark.
  task automatic wait_period_start(input string tag, input int expect_clks);
    int seen_at = 0;
    for (int i = 1; i <= 64; i++) begin
      step();
      check({tag, "_rgb_dark"}, 8'(rgb), 8'(COLOR_OFF_N));
      if (period_start) begin
        seen_at = i;
        break;
      end
    end
    check({tag, "_first_period_start"}, 8'(seen_at), 8'(expect_clks));
  endtask

  // Called on a period_start cycle; checks the next 32 clks of pin output.
  // mode 0: no offer; 1: offer at start; 2: offer at start then hold junk
  // while blocked; 3: offer so it is accepted on the wrap clk of this period.
  task automatic run_period(input string tag, input logic [2:0] color, input int duty,
                            input int mode, input logic [2:0] nc, input logic [3:0] nb);
    if (mode == 1 || mode == 2) begin
      bus.in_valid   = 1'b1;
      bus.color_n    = nc;
      bus.brightness = nb;
    end
    for (int i = 0; i < 32; i++) begin
      step();
      check({tag, "_rgb"}, 8'(rgb), 8'(((i / 2) < duty) ? color : COLOR_OFF_N));
      check({tag, "_period_start"}, 8'(period_start), 8'(i == 31));
      if (i == 0 && (mode == 1 || mode == 2)) begin
        check({tag, "_ready_low_after_accept"}, 8'(bus.in_ready), 8'd0);
      end
      bus.in_valid = 1'b0;
      if (mode == 2 && i < 30) begin
        bus.in_valid   = 1'b1;
        bus.color_n    = COLOR_ERR_N;
        bus.brightness = 4'd15;
      end
      if (mode == 3 && i == 30) begin
        bus.in_valid   = 1'b1;
        bus.color_n    = nc;
        bus.brightness = nb;
      end
    end
    bus.in_valid = 1'b0;
    check({tag, "_ready_at_boundary"}, 8'(bus.in_ready), (mode == 3) ? 8'd0 : 8'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid   = 1'b0;
    bus.color_n    = COLOR_OFF_N;
    bus.brightness = '0;

    // 1: reset state, then first period_start 32 clks after release
    rst = 1'b0;
    repeat (5) step();
    check("reset_rgb", 8'(rgb), 8'(COLOR_OFF_N));
    check("reset_in_ready", 8'(bus.in_ready), 8'd1);
    check("reset_period_start", 8'(period_start), 8'd0);
    rst = 1'b1;
    wait_period_start("release", 32);

    // 2: red duty 8 waits for the wrap, then 16 on / 16 off
    run_period("red8_queued", COLOR_OFF_N, 0, 1, COLOR_RED_N, 4'd8);
    run_period("red8_shown", COLOR_RED_N, 8, 0, COLOR_OFF_N, 4'd0);

    // 3: limits -- duty 0 is dark, duty 15 is on 30 of 32 clks
    run_period("red8_hold", COLOR_RED_N, 8, 1, COLOR_RED_N, 4'd0);
    run_period("duty0", COLOR_RED_N, 0, 1, COLOR_BLUE_N, 4'd15);

    // 4: back-pressure -- junk held on the bus while blocked is ignored
    run_period("duty15", COLOR_BLUE_N, 15, 2, COLOR_GREEN_N, 4'd5);
    run_period("bp_green5", COLOR_GREEN_N, 5, 0, COLOR_OFF_N, 4'd0);

    // 5: accept on the wrap clk -> old setting runs one more period
    run_period("wrap_accept", COLOR_GREEN_N, 5, 3, COLOR_BLUE_N, 4'd3);
    run_period("wrap_old_kept", COLOR_GREEN_N, 5, 0, COLOR_OFF_N, 4'd0);
    run_period("wrap_blue3", COLOR_BLUE_N, 3, 1, COLOR_ERR_N, 4'd6);

    // error colour is displayed as white
    run_period("err_white", COLOR_ERR_N, 6, 1, COLOR_GREEN_N, 4'd12);

    // 6: green 12 active, white queued, reset at clk 10 of the period
    bus.in_valid   = 1'b1;
    bus.color_n    = COLOR_ERR_N;
    bus.brightness = 4'd15;
    for (int i = 0; i < 10; i++) begin
      step();
      check("g12_rgb", 8'(rgb), 8'(((i / 2) < 12) ? COLOR_GREEN_N : COLOR_OFF_N));
      if (i == 0) begin
        check("g12_white_pending", 8'(bus.in_ready), 8'd0);
      end
      bus.in_valid = 1'b0;
    end
    rst = 1'b0;
    step();
    check("midrst_rgb", 8'(rgb), 8'(COLOR_OFF_N));
    check("midrst_in_ready", 8'(bus.in_ready), 8'd1);
    check("midrst_period_start", 8'(period_start), 8'd0);
    step();
    rst = 1'b1;
    wait_period_start("midrst_release", 32);
    run_period("white_discarded", COLOR_OFF_N, 0, 0, COLOR_OFF_N, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
